spi_ram_ctrl: RTL

- Command decoder and single-port-access memory that sits directly downstream of the SPI slave.
- Consumes the slave's 11-bit rx_data/rx_valid frames and executes write-address, write-data, read-address and read-data commands on an internal 2**ADDR_SIZE x 8 RAM.
- Returns read bytes to the slave on tx_data/tx_valid, holding them long enough for the slave to shift them out on MISO.

---
 rtl/spi_ram_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: command decoder and 2**ADDR_SIZE x 8 RAM behind an SPI slave.
// Each rising edge of rx_valid executes one command. Read responses are held
// on tx_data/tx_valid for TX_HOLD cycles so the slave can shift them out.
module spi_ram_ctrl #(
  parameter int ADDR_SIZE = 8,
  parameter int TX_HOLD   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        cmd_err
);

  localparam int CNT_W = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;
  localparam int DEPTH = 2 ** ADDR_SIZE;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_FETCH = 2'd1,
    RD_RESP  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic                 rx_valid_q;
  logic                 accept;
  logic [1:0]           cmd;
  logic [7:0]           payload;
  logic [ADDR_SIZE-1:0] payload_addr;
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
  logic                 rd_armed;
  logic [CNT_W-1:0]     hold_cnt;
  logic [7:0]           rd_buf;
  logic [7:0]           mem [DEPTH];

  // Decoded one-cycle strobes from the FSM
  logic wr_addr_ld, wr_data_ld, rd_addr_ld, fetch, resp_start, resp_done, err;

  // Bit 10 of the frame carries nothing for this block
  logic unused_rx_bit;
  assign unused_rx_bit = rx_data[10];

  assign accept       = rx_valid & ~rx_valid_q;
  assign cmd          = rx_data[9:8];
  assign payload      = rx_data[7:0];
  assign payload_addr = rx_data[ADDR_SIZE-1:0];

  // Edge detector on rx_valid so a held level runs its command only once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_valid_q <= 1'b0;
    else     rx_valid_q <= rx_valid;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and command decode; anything accepted while busy is rejected
  always_comb begin
    state_nxt  = state;
    wr_addr_ld = 1'b0;
    wr_data_ld = 1'b0;
    rd_addr_ld = 1'b0;
    fetch      = 1'b0;
    resp_start = 1'b0;
    resp_done  = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd)
            2'b00:   wr_addr_ld = 1'b1;
            2'b01:   wr_data_ld = 1'b1;
            2'b10:   rd_addr_ld = 1'b1;
            default: begin
              if (rd_armed) state_nxt = RD_FETCH;
              else          err       = 1'b1;
            end
          endcase
        end
      end
      RD_FETCH: begin
        fetch     = 1'b1;
        err       = accept;
        state_nxt = RD_RESP;
      end
      RD_RESP: begin
        err = accept;
        // tx_valid is low only on the first cycle of a response
        if (!tx_valid) begin
          resp_start = 1'b1;
        end else if (hold_cnt == '0) begin
          resp_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address registers, read arming and the error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      rd_armed <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      cmd_err <= err;
      if (wr_addr_ld) wr_addr <= payload_addr;
      else if (wr_data_ld) wr_addr <= wr_addr + 1'b1;
      if (rd_addr_ld) begin
        rd_addr  <= payload_addr;
        rd_armed <= 1'b1;
      end else if (resp_done) begin
        rd_addr  <= rd_addr + 1'b1;
        rd_armed <= 1'b0;
      end
    end
  end

  // Response output and hold counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      hold_cnt <= '0;
    end else if (resp_start) begin
      tx_data  <= rd_buf;
      tx_valid <= 1'b1;
      hold_cnt <= CNT_W'(TX_HOLD - 1);
    end else if (resp_done) begin
      tx_valid <= 1'b0;
    end else if (tx_valid) begin
      hold_cnt <= hold_cnt - 1'b1;
    end
  end

  // RAM array and fetch buffer; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_data_ld) mem[wr_addr] <= payload;
    if (fetch)      rd_buf       <= mem[rd_addr];
  end

endmodule
